// File: rtl/fpdiv_ctrl.sv
// Sequencer for the Goldschmidt divider datapath: drives mux selects and A/B/C load enables.
// Optional build macro FPDIV_CTRL_LASTSKIP_EN skips the final ITER_D, whose B/C results are unused.
module fpdiv_ctrl #(
    parameter int ITERS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       sel_mux2,
    output logic [1:0] sel_mux4,
    output logic       en_a,
    output logic       en_b,
    output logic       en_c,
    output logic [3:0] iter
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT_Q = 3'd1,
        INIT_D = 3'd2,
        ITER_Q = 3'd3,
        ITER_D = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [3:0] LAST_ITER = 4'(ITERS - 1);

    generate
        if (ITERS < 1 || ITERS > 15) begin : g_iters_range
            $error("fpdiv_ctrl: ITERS must be in 1..15");
        end
    endgenerate

    state_t     state_reg, state_next;
    logic [3:0] iter_reg, iter_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            iter_reg  <= 4'd0;
        end else begin
            state_reg <= state_next;
            iter_reg  <= iter_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        iter_next  = iter_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = INIT_Q;
                    iter_next  = 4'd0;
                end
            end
            INIT_Q: state_next = INIT_D;
            INIT_D: state_next = ITER_Q;
            ITER_Q: begin
`ifdef FPDIV_CTRL_LASTSKIP_EN
                if (iter_reg == LAST_ITER)
                    state_next = DONE;
                else
                    state_next = ITER_D;
`else
                state_next = ITER_D;
`endif
            end
            ITER_D: begin
                // Counter saturates at the last index; it never wraps.
                if (iter_reg < LAST_ITER) begin
                    state_next = ITER_Q;
                    iter_next  = iter_reg + 4'd1;
                end else begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        sel_mux2 = 1'b0;
        sel_mux4 = 2'd0;
        en_a     = 1'b0;
        en_b     = 1'b0;
        en_c     = 1'b0;
        iter     = 4'd0;
        case (state_reg)
            INIT_Q: begin
                busy = 1'b1;
                en_a = 1'b1;
            end
            INIT_D: begin
                busy     = 1'b1;
                sel_mux4 = 2'd1;
                en_b     = 1'b1;
                en_c     = 1'b1;
            end
            ITER_Q: begin
                busy     = 1'b1;
                sel_mux2 = 1'b1;
                sel_mux4 = 2'd2;
                en_a     = 1'b1;
                iter     = iter_reg;
            end
            ITER_D: begin
                busy     = 1'b1;
                sel_mux2 = 1'b1;
                sel_mux4 = 2'd3;
                en_b     = 1'b1;
                en_c     = 1'b1;
                iter     = iter_reg;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Scoreboard bench for fpdiv_ctrl: two instances (ITERS=3 and ITERS=1) driven by shared start/reset.
// Expected per-cycle outputs come from a cycle-position model pushed at drive time, popped after each edge.
module tb_fpdiv_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic start;

    logic       busy3, done3, sel_mux2_3, en_a3, en_b3, en_c3;
    logic [1:0] sel_mux4_3;
    logic [3:0] iter3;
    logic       busy1, done1, sel_mux2_1, en_a1, en_b1, en_c1;
    logic [1:0] sel_mux4_1;
    logic [3:0] iter1;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FPDIV_CTRL_LASTSKIP_EN
    localparam int LAST3 = 2 + 2 * 3;
    localparam int LAST1 = 2 + 2 * 1;
`else
    localparam int LAST3 = 3 + 2 * 3;
    localparam int LAST1 = 3 + 2 * 1;
`endif

    fpdiv_ctrl #(.ITERS(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy3), .done(done3), .sel_mux2(sel_mux2_3), .sel_mux4(sel_mux4_3),
        .en_a(en_a3), .en_b(en_b3), .en_c(en_c3), .iter(iter3)
    );

    fpdiv_ctrl #(.ITERS(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy1), .done(done1), .sel_mux2(sel_mux2_1), .sel_mux4(sel_mux4_1),
        .en_a(en_a1), .en_b(en_b1), .en_c(en_c1), .iter(iter1)
    );

    always #5 clk = ~clk;

    logic [23:0] exp_q[$];
    int ph3 = 0;
    int ph1 = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, expv, $time);
        end
    endtask

    // ph = cycles since the accepted start (0 = idle); last = the done cycle
    function automatic logic [11:0] exp_vec(input int ph, input int last);
        logic       b, d, m2, ea, eb;
        logic [1:0] m4;
        logic [3:0] it;
        b = 0; d = 0; m2 = 0; ea = 0; eb = 0; m4 = 2'd0; it = 4'd0;
        if (ph == 0) begin
        end else if (ph == last) begin
            d = 1;
        end else if (ph == 1) begin
            b = 1; ea = 1;
        end else if (ph == 2) begin
            b = 1; eb = 1; m4 = 2'd1;
        end else begin
            b = 1; m2 = 1; it = 4'((ph - 3) / 2);
            if (((ph - 3) % 2) == 0) begin
                ea = 1; m4 = 2'd2;
            end else begin
                eb = 1; m4 = 2'd3;
            end
        end
        return {b, d, m2, m4, ea, eb, eb, it};
    endfunction

    function automatic int nxt(input int ph, input logic s, input int last);
        if (!reset)        return 0;
        else if (ph == 0)  return s ? 1 : 0;
        else if (ph == last) return 0;
        else               return ph + 1;
    endfunction

    task automatic step(input logic s);
        @(negedge clk);
        start = s;
        ph3 = nxt(ph3, s, LAST3);
        ph1 = nxt(ph1, s, LAST1);
        exp_q.push_back({exp_vec(ph3, LAST3), exp_vec(ph1, LAST1)});
        $display("drive start=%0b ph3=%0d ph1=%0d", s, ph3, ph1);
    endtask

    function automatic logic [11:0] act3();
        return {busy3, done3, sel_mux2_3, sel_mux4_3, en_a3, en_b3, en_c3, iter3};
    endfunction

    function automatic logic [11:0] act1();
        return {busy1, done1, sel_mux2_1, sel_mux4_1, en_a1, en_b1, en_c1, iter1};
    endfunction

    always @(posedge clk) begin
        logic [23:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outs_iters3", 32'(act3()), 32'(e[23:12]));
            check("outs_iters1", 32'(act1()), 32'(e[11:0]));
            check("onehot_en3", 32'(en_a3 & (en_b3 | en_c3)), 32'd0);
            check("onehot_en1", 32'(en_a1 & (en_b1 | en_c1)), 32'd0);
        end
    end

    task automatic abort_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        ph3 = 0;
        ph1 = 0;
        exp_q.delete();
        #1;
        check("abort_iters3", 32'(act3()), 32'd0);
        check("abort_iters1", 32'(act1()), 32'd0);
        $display("async reset asserted mid-sequence at %0t", $time);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        #1;
        check("reset_iters3", 32'(act3()), 32'd0);
        check("reset_iters1", 32'(act1()), 32'd0);
        step(0);
        step(0);
        reset = 1'b1;
        repeat (3) step(0);

        // single start pulse
        step(1);
        repeat (12) step(0);

        // start held high: restarts every done+1 cycles, ignored while busy
        repeat (30) step(1);
        repeat (12) step(0);

        // abort mid-sequence, then no done until a fresh start
        step(1);
        repeat (4) step(0);
        abort_reset();
        step(0);
        step(0);
        reset = 1'b1;
        repeat (12) step(0);
        step(1);
        repeat (12) step(0);

        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpdiv_ctrl.md
# fpdiv_ctrl

Sequencer for the Goldschmidt divider datapath (`fpdiv`). It accepts a start request and then drives the datapath's mux selects and the register enables for the A, B and C registers. It runs one initial scaling step and then a fixed number of refinement iterations. It signals completion when register A holds the quotient estimate. It sits between the FP unit's issue logic and the `fpdiv` datapath, and it owns no arithmetic.

## Interface
- `ITERS`, default 3: number of refinement iterations. Legal range is 1..15.
- `clk`  input  1  clock; every flop is rising-edge triggered.
- `reset`  input  1  asynchronous reset, active-low (asserted at 0).
- `start`  input  1  request a division; sampled only in IDLE.
- `busy`  output  1  high from the first sequencing cycle through the last enable cycle.
- `done`  output  1  one-cycle pulse; register A holds the quotient in this cycle.
- `sel_mux2`  output  1  0 selects the initial approximation; 1 selects register C.
- `sel_mux4`  output  2  0 selects num, 1 selects denom, 2 selects register A, 3 selects register B.
- `en_a`, `en_b`, `en_c`  output  1 each  load enables for registers A, B and C.
- `iter`  output  4  current refinement index (0-based); 0 outside the ITER states.

## Operation
- State machine states: IDLE, INIT_Q, INIT_D, ITER_Q, ITER_D, DONE. Encoding is free.
- Outputs per state:
  - IDLE and DONE: all enables 0, sel_mux2=0, sel_mux4=0.
  - INIT_Q: sel_mux2=0, sel_mux4=0, en_a=1. A loads x0·N.
  - INIT_D: sel_mux2=0, sel_mux4=1, en_b=1, en_c=1. B loads x0·D; C loads the one's complement of the same product.
  - ITER_Q: sel_mux2=1, sel_mux4=2, en_a=1. A loads r·q.
  - ITER_D: sel_mux2=1, sel_mux4=3, en_b=1, en_c=1. B loads r·d; C loads the complement of r·d.
- Transitions:
  - IDLE goes to INIT_Q on start=1.
  - INIT_Q goes to INIT_D, then INIT_D goes to ITER_Q.
  - ITER_Q goes to ITER_D.
  - ITER_D goes to ITER_Q and increments `iter` while `iter` < ITERS-1. Otherwise it goes to DONE.
  - DONE goes to IDLE.
- `start` is ignored in every state except IDLE; there is no queuing.
- The source holds num and denom stable from the start cycle until done.
- Only one enable group is active per cycle: {en_a} or {en_b, en_c}, never both.
- Every output is a decode of registered state and counter only, with no combinational path from `start`.
- `iter` is a 4-bit counter. It clears on entry to INIT_Q and never wraps; ITERS ≤ 15 is checked by an elaboration-time assertion.

## Timing
- Reset:
  - Asserting reset (reset=0) forces IDLE and iter=0 immediately. All outputs go to 0 asynchronously.
  - Deassertion is synchronised externally, so the first sampling edge after deassertion is clean.
- Reset mid-operation aborts the division. Register contents are don't-care; no done pulse is produced.
- Let start be sampled high at edge 0. Then:
  - INIT_Q occupies cycle 1 and INIT_D occupies cycle 2.
  - ITER pairs occupy cycles 3 .. 2+2·ITERS.
  - `done` is high in cycle 3+2·ITERS.
  - `busy` is high in cycles 1 .. 2+2·ITERS.
- The earliest next accepted start is sampled at the edge that ends the IDLE cycle following DONE.
- `start` held high continuously restarts a new division every 4+2·ITERS cycles.

## Configuration
- `FPDIV_CTRL_LASTSKIP_EN` selects whether the final ITER_D runs.
- **Defined:**
  - The final ITER_D is skipped, because its B and C values are never consumed.
  - ITER_Q with `iter` = ITERS-1 goes directly to DONE.
  - `done` moves to cycle 2+2·ITERS and `busy` spans cycles 1 .. 1+2·ITERS.
  - The enable pattern is otherwise identical.
- **Undefined:** the full sequence runs as described above. This is the default.

## Test plan
- ITERS=3, start pulse at cycle 0. Required response:
  - en_a=1 in cycles 1, 3, 5, 7; en_b=en_c=1 in cycles 2, 4, 6, 8.
  - sel_mux4 sequence 0,1,2,3,2,3,2,3; sel_mux2 sequence 0,0,1,1,1,1,1,1.
  - busy high in cycles 1–8; done=1 only in cycle 9; iter values 0,0,1,1,2,2 across cycles 3–8.
- Same stimulus with `FPDIV_CTRL_LASTSKIP_EN` defined: no en_b or en_c in cycle 8; done=1 in cycle 8; busy high in cycles 1–7.
- start held high for 30 cycles with ITERS=3: done pulses at cycles 9, 19 and 29; start is ignored while busy or done.
- reset driven to 0 in cycle 5 mid-sequence: all outputs are 0 in that same cycle. After release, no done appears until a new start; the next start yields done exactly 9 cycles later.
- ITERS=1: cycle sequence is INIT_Q, INIT_D, ITER_Q, ITER_D, then done in cycle 5. With `FPDIV_CTRL_LASTSKIP_EN`, done is in cycle 4.
- Integrated with `fpdiv`, num = denom: after done, register A is within 2 ulp of 1.0. A one-hot-enable assertion and a no-enable-in-IDLE assertion are checked throughout.
